// File: rtl/jt5205_timing_if.sv
// jt5205_timing_if: control and strobe bundle between the sample-timing
// divider (slave) and whatever drives it (master). clk/rst stay outside.
`timescale 1ns/1ps

interface jt5205_timing_if #(
    parameter int CW  = 8,
    parameter int NCH = 1
);
    logic           cen;
    logic [2:0]     sel;
    logic [CW-1:0]  lim_cfg;
    logic           resync;
    logic [NCH-1:0] cen_lo;
    logic [NCH-1:0] cenb_lo;
    logic           cen_mid;
    logic           stopped;
    logic [CW-1:0]  phase;

    modport master (
        output cen, sel, lim_cfg, resync,
        input  cen_lo, cenb_lo, cen_mid, stopped, phase
    );

    modport slave (
        input  cen, sel, lim_cfg, resync,
        output cen_lo, cenb_lo, cen_mid, stopped, phase
    );
endinterface

// File: rtl/jt5205_timing_gen.sv
// jt5205_timing_gen: divides the chip clock enable into per-channel sample
// (cen_lo) and half-period (cenb_lo) strobes. Fixed periods 96/64/48/2, a
// programmable period, and a stop mode. Mode changes are taken only at the
// end of a period, so no shortened or stretched period is ever emitted.
// Up to four channels share one counter with evenly staggered phases.
// Optional build macro JT5205_TIMING_RESYNC_EN enables the resync input
// (restart the period at phase 0); without it resync is ignored.
`timescale 1ns/1ps

module jt5205_timing_gen #(
    parameter int CW  = 8,
    parameter int NCH = 1
) (
    input  logic             clk,
    input  logic             rst,
    jt5205_timing_if.slave   bus
);
    localparam int LOG2_NCH = (NCH == 4) ? 2 : (NCH == 2) ? 1 : 0;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_lim;
    logic [CW-1:0]  r_tgt_pre  [NCH];
    logic [CW-1:0]  r_tgt_preb [NCH];
    logic [NCH-1:0] r_pre;
    logic [NCH-1:0] r_preb;

    logic [CW-1:0]  w_lim_n;
    logic           w_stop_req;
    logic [CW:0]    w_period;
    logic [CW:0]    w_seg;
    logic [CW:0]    w_off;
    logic [CW:0]    w_sum;
    logic [CW-1:0]  w_tgt_pre  [NCH];
    logic [CW-1:0]  w_tgt_preb [NCH];
    logic           w_wrap;
    logic           w_pending;

    // Mode decode: requested period minus one, or a stop request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        w_lim_n    = CW'(95);
        w_stop_req = 1'b0;
        case (bus.sel)
            3'd0:    w_lim_n = CW'(95);
            3'd1:    w_lim_n = CW'(63);
            3'd2:    w_lim_n = CW'(47);
            3'd3:    w_lim_n = CW'(1);
            3'd4:    w_lim_n = (bus.lim_cfg == '0) ? CW'(1) : bus.lim_cfg;
            default: w_stop_req = 1'b1;
        endcase
    end

    // Per-channel match counts for the period about to be loaded.
    always_comb begin
        w_period = {1'b0, w_lim_n} + (CW+1)'(1);
        w_seg    = w_period >> LOG2_NCH;
        w_off    = '0;
        w_sum    = '0;
        for (int k = 0; k < NCH; k++) begin
            // Offsets stay below the period, so they fit in CW bits.
            w_off = w_seg * (CW+1)'(k);
            w_sum = w_off + {2'b00, w_lim_n[CW-1:1]};
            w_tgt_pre[k]  = (w_off == '0) ? w_lim_n : (w_off[CW-1:0] - CW'(1));
            w_tgt_preb[k] = (w_sum >= w_period) ? CW'(w_sum - w_period)
                                                : w_sum[CW-1:0];
        end
    end

    assign w_wrap    = (r_cnt == r_lim);
    assign w_pending = w_stop_req || (w_lim_n != r_lim);

    // Period FSM, counter and strobe flags; everything advances on cen only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_lim   <= CW'(95);
            r_pre   <= '0;
            r_preb  <= '0;
            // NOTE: the match tables are a handful of flops, so they take the
            // reset as well; LOAD always rewrites them before RUN reads them.
            for (int k = 0; k < NCH; k++) begin
                r_tgt_pre[k]  <= '0;
                r_tgt_preb[k] <= '0;
            end
        end else if (bus.cen) begin
            // NOTE: non-blocking throughout, so a later assignment in this
            // block overrides the flag clear below without ordering hazards.
            r_pre  <= '0;
            r_preb <= '0;
            case (r_state)
                ST_LOAD: begin
                    r_cnt <= '0;
                    if (w_stop_req) begin
                        r_state <= ST_STOP;
                    end else begin
                        r_lim <= w_lim_n;
                        for (int k = 0; k < NCH; k++) begin
                            r_tgt_pre[k]  <= w_tgt_pre[k];
                            r_tgt_preb[k] <= w_tgt_preb[k];
                        end
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (r_cnt == r_tgt_pre[k])  r_pre[k]  <= 1'b1;
                        if (r_cnt == r_tgt_preb[k]) r_preb[k] <= 1'b1;
                    end
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (w_pending) r_state <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`ifdef JT5205_TIMING_RESYNC_EN
                    // Resync overrides the count; only a coincident wrap
                    // still produces the channel-0 sample strobe.
                    if (bus.resync) begin
                        r_cnt    <= '0;
                        r_pre    <= '0;
                        r_pre[0] <= w_wrap;
                        r_preb   <= '0;
                        if (w_pending) r_state <= ST_LOAD;
                    end
`endif
                end
                ST_STOP: begin
                    r_cnt <= '0;
                    if (!w_stop_req) r_state <= ST_LOAD;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.cen_lo  = r_pre  & {NCH{bus.cen}};
    assign bus.cenb_lo = r_preb & {NCH{bus.cen}};
    assign bus.cen_mid = (r_pre[0] | r_preb[0]) & bus.cen;
    assign bus.stopped = (r_state == ST_STOP);
    assign bus.phase   = r_cnt;

endmodule

// File: tb/tb_jt5205_timing_gen.sv
// tb_jt5205_timing_gen: drives an NCH=1 and an NCH=4 divider with the same
// controls and checks both against a period-arithmetic model every clock,
// plus literal interval expectations for the main scenarios.
`timescale 1ns/1ps

module tb_jt5205_timing_gen;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic [2:0]    sel = 3'd0;
    logic [CW-1:0] lim_cfg = '0;
    logic          resync = 1'b0;

    always #5 clk = ~clk;

    jt5205_timing_if #(.CW(CW), .NCH(1)) bus0 ();
    jt5205_timing_if #(.CW(CW), .NCH(4)) bus1 ();

    assign bus0.cen = cen;      assign bus1.cen = cen;
    assign bus0.sel = sel;      assign bus1.sel = sel;
    assign bus0.lim_cfg = lim_cfg;  assign bus1.lim_cfg = lim_cfg;
    assign bus0.resync = resync;    assign bus1.resync = resync;

    jt5205_timing_gen #(.CW(CW), .NCH(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    jt5205_timing_gen #(.CW(CW), .NCH(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ncen  = 0;

    // Model: mode 0 idle-load, 1 running, 2 stopped. In running mode the
    // position within the period is (cen index - start) mod period.
    int         m_mode [2];
    int         m_per  [2];
    int         m_start[2];
    int         m_off  [2][4];
    logic [3:0] m_lo   [2];
    logic [3:0] m_lob  [2];

    int q_lo0[$];
    int q_lob0[$];
    int last_lo1[4];
    int last_lob1[4];
    int n_strobe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int modp(input int a, input int p);
        int r;
        r = a % p;
        return (r < 0) ? r + p : r;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000000;
    endfunction

    // Period minus one for the current controls, -1 meaning stop.
    function automatic int lim_of(input logic [2:0] s, input logic [CW-1:0] lc);
        case (s)
            3'd0: return 95;
            3'd1: return 63;
            3'd2: return 47;
            3'd3: return 1;
            3'd4: return (lc == 0) ? 1 : int'(lc);
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_mode[u] = 0; m_per[u] = 96; m_start[u] = 0;
            m_lo[u] = '0;  m_lob[u] = '0;
        end
    endtask

    task automatic model_advance(input int u, input int n);
        int ln, nch, c, seg;
        bit stp, wrap, pend;
        logic [3:0] lo, lob;
        ln  = lim_of(sel, lim_cfg);
        stp = (ln < 0);
        nch = (u == 0) ? 1 : 4;
        lo = '0; lob = '0;
        case (m_mode[u])
            0: begin
                if (stp) m_mode[u] = 2;
                else begin
                    m_per[u] = ln + 1;
                    seg = m_per[u] / nch;
                    for (int k = 0; k < nch; k++) m_off[u][k] = k * seg;
                    m_start[u] = n + 1;
                    m_mode[u] = 1;
                end
            end
            2: if (!stp) m_mode[u] = 0;
            default: begin
                c = modp(n - m_start[u], m_per[u]);
                for (int k = 0; k < nch; k++) begin
                    if (modp(c + 1 - m_off[u][k], m_per[u]) == 0) lo[k] = 1'b1;
                    if (modp(c - m_off[u][k] - (m_per[u] - 1) / 2, m_per[u]) == 0) lob[k] = 1'b1;
                end
                wrap = (c == m_per[u] - 1);
                pend = stp || (ln + 1 != m_per[u]);
`ifdef JT5205_TIMING_RESYNC_EN
                if (resync) begin
                    lo = {3'b000, wrap};
                    lob = '0;
                    m_start[u] = n + 1;
                    if (pend) m_mode[u] = 0;
                end else
`endif
                if (wrap && pend) m_mode[u] = 0;
            end
        endcase
        m_lo[u] = lo;
        m_lob[u] = lob;
    endtask

    // Compare both DUTs against the model, then advance the model by the
    // upcoming cen edge (inputs are stable from here to the posedge).
    task automatic compare();
        logic [3:0] lo[2], lob[2], elo, elob;
        logic mid[2], stp[2];
        logic [31:0] ph[2], eph;
        if (rst) model_reset();
        lo[0] = {3'b000, bus0.cen_lo}; lob[0] = {3'b000, bus0.cenb_lo};
        mid[0] = bus0.cen_mid; stp[0] = bus0.stopped; ph[0] = 32'(bus0.phase);
        lo[1] = bus1.cen_lo; lob[1] = bus1.cenb_lo;
        mid[1] = bus1.cen_mid; stp[1] = bus1.stopped; ph[1] = 32'(bus1.phase);
        for (int u = 0; u < 2; u++) begin
            elo  = cen ? m_lo[u]  : 4'b0;
            elob = cen ? m_lob[u] : 4'b0;
            eph  = (m_mode[u] == 1) ? 32'(modp(ncen - m_start[u], m_per[u])) : 32'd0;
            check(u == 0 ? "u0 cen_lo"  : "u1 cen_lo",  lo[u],  elo);
            check(u == 0 ? "u0 cenb_lo" : "u1 cenb_lo", lob[u], elob);
            check(u == 0 ? "u0 cen_mid" : "u1 cen_mid", mid[u], elo[0] | elob[0]);
            check(u == 0 ? "u0 stopped" : "u1 stopped", stp[u], m_mode[u] == 2);
            check(u == 0 ? "u0 phase"   : "u1 phase",   ph[u],  eph);
        end
        if (lo[0][0])  q_lo0.push_back(cyc);
        if (lob[0][0]) q_lob0.push_back(cyc);
        for (int k = 0; k < 4; k++) begin
            if (lo[1][k])  last_lo1[k]  = cyc;
            if (lob[1][k]) last_lob1[k] = cyc;
        end
        n_strobe += $countones(lo[0]) + $countones(lob[0]) + $countones(lo[1]) + $countones(lob[1]);
        if (cen && !rst) begin
            model_advance(0, ncen);
            model_advance(1, ncen);
            ncen++;
        end
    endtask

    task automatic step(input bit c);
        cen = c;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic wait_phase(input int target, input int budget);
        for (int i = 0; i < budget && int'(bus0.phase) != target; i++) step(1'b1);
        check("wait phase", 32'(bus0.phase), 32'(target));
    endtask

    initial begin
        int t0, i0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0);
        rst = 1'b0;
        check("reset phase", 32'(bus0.phase), 0);
        check("reset stopped", 32'(bus0.stopped), 0);
        check("reset cen_lo", 32'(bus1.cen_lo), 0);

        // sel 0, cen every 4 clk: first LOAD, then 96-cen periods.
        sel = 3'd0;
        q_lo0.delete(); q_lob0.delete();
        t0 = cyc;
        for (int i = 0; i < 1300; i++) step(i % 4 == 0);
        check("first cen_lo", qat(q_lo0, 0) - t0, 388);
        check("cen_lo period a", qat(q_lo0, 1) - qat(q_lo0, 0), 384);
        check("cen_lo period b", qat(q_lo0, 2) - qat(q_lo0, 1), 384);
        check("cenb after cen_lo", qat(q_lob0, 1) - qat(q_lo0, 0), 192);

        // Custom period 10, then lim_cfg=0 clamps to period 2.
        sel = 3'd4; lim_cfg = 8'd9;
        run(150);
        q_lo0.delete();
        run(40);
        check("custom period a", qat(q_lo0, 1) - qat(q_lo0, 0), 10);
        check("custom period b", qat(q_lo0, 2) - qat(q_lo0, 1), 10);
        lim_cfg = 8'd0;
        run(30);
        q_lo0.delete();
        run(10);
        check("clamped period", qat(q_lo0, 1) - qat(q_lo0, 0), 2);

        // sel 0 -> 2 at cnt 40: 96 completes, LOAD adds one, then 48.
        sel = 3'd0;
        run(250);
        wait_phase(40, 200);
        i0 = q_lo0.size() - 1;
        sel = 3'd2;
        run(200);
        check("switch old period", qat(q_lo0, i0 + 1) - qat(q_lo0, i0), 96);
        check("switch load gap", qat(q_lo0, i0 + 2) - qat(q_lo0, i0 + 1), 49);
        check("switch new period", qat(q_lo0, i0 + 3) - qat(q_lo0, i0 + 2), 48);

        // Stop mid-period, silent for 1000 cen, then period 2.
        sel = 3'd6;
        for (int i = 0; i < 100 && !bus0.stopped; i++) step(1'b1);
        check("entered stop", 32'(bus0.stopped), 1);
        n_strobe = 0;
        run(1000);
        check("silent while stopped", n_strobe, 0);
        q_lo0.delete();
        sel = 3'd3;
        t0 = cyc;
        run(20);
        check("restart first strobe", qat(q_lo0, 0) - t0, 4);
        check("restart period", qat(q_lo0, 1) - qat(q_lo0, 0), 2);

        // NCH=4 at period 64: channels 16 apart, cenb 32 after cen_lo.
        sel = 3'd1;
        for (int k = 0; k < 4; k++) begin last_lo1[k] = -100000; last_lob1[k] = -100000; end
        run(200);
        for (int k = 1; k < 4; k++)
            check("nch4 stagger", modp(last_lo1[k] - last_lo1[0], 64), 16 * k);
        for (int k = 0; k < 4; k++)
            check("nch4 half period", modp(last_lob1[k] - last_lo1[k], 64), 32);

        // Reset mid-period at cnt 30.
        sel = 3'd0;
        wait_phase(30, 300);
        rst = 1'b1;
        step(1'b1);
        check("rst phase", 32'(bus0.phase), 0);
        check("rst cen_lo", 32'(bus1.cen_lo), 0);
        step(1'b1);
        rst = 1'b0;
        q_lo0.delete();
        t0 = cyc;
        run(120);
        check("post reset first strobe", qat(q_lo0, 0) - t0, 97);

`ifdef JT5205_TIMING_RESYNC_EN
        // Resync at cnt 50: count restarts, 96 cen later the wrap strobes.
        wait_phase(50, 200);
        resync = 1'b1;
        q_lo0.delete();
        t0 = cyc;
        step(1'b1);
        resync = 1'b0;
        run(110);
        check("resync strobe", qat(q_lo0, 0) - t0, 97);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jt5205_timing_gen.md
Name: jt5205_timing_gen

Overview:
- Parametrised successor to the MSM5205 sample-timing divider.
- Divides the chip clock enable (`cen`) into sample-rate strobes. Supports:
  - the four fixed prescaler modes;
  - a runtime-programmable custom divider;
  - a stop mode;
  - glitch-free mode changes;
  - up to four phase-staggered channel strobes sharing one counter.
- Sits between the clock-enable generator and one or more ADPCM decoder cores.

Parameters:
- CW, 8, counter and limit width in bits (minimum 7).
- NCH, 1, number of staggered channel strobe pairs; legal values 1, 2, 4.

Ports:
- rst  in  1  asynchronous reset, active high.
- clk  in  1  system clock; single clock domain.
- cen  in  1  chip clock enable; all state advances only when cen=1.
- sel  in  3  mode select:
  - 0 = period 96, 1 = period 64, 2 = period 48, 3 = period 2;
  - 4 = custom period, lim_cfg+1;
  - 5..7 = stop.
- lim_cfg  in  CW  custom period minus one; used in mode 4 only. Values below 1 are treated as 1.
- resync  in  1  restart the period at phase 0 (see Optional Feature).
- cen_lo  out  NCH  per-channel sample strobe; one clk wide, coincident with cen.
- cenb_lo  out  NCH  per-channel half-period strobe; one clk wide, coincident with cen.
- cen_mid  out  1  OR of cen_lo[0] and cenb_lo[0].
- stopped  out  1  high while in STOP state.
- phase  out  CW  current counter value, for debug and testbench.

Behaviour:
- Reset values (all asynchronous):
  - cnt=0, lim_r=95, state=LOAD;
  - all strobe flags 0, so all outputs 0;
  - stopped=0.
- Mode decode (combinational):
  - lim_n = 95 / 63 / 47 / 1 for sel 0..3;
  - lim_n = max(lim_cfg,1) for sel 4;
  - stop request for sel 5..7.
- FSM, evaluated only on cycles with cen=1:
  - LOAD:
    - if stop requested → STOP;
    - else lim_r←lim_n, compute offsets, cnt←0, → RUN;
    - no strobes are produced in this cycle.
  - RUN:
    - cnt increments by 1;
    - on cnt==lim_r: cnt←0 and set pre flag for channel 0;
    - at the wrap, if lim_n≠lim_r or a stop is requested, → LOAD. The period in progress always completes, so no shortened or stretched period is ever emitted.
  - STOP:
    - cnt held at 0, no flags set, stopped=1;
    - when sel leaves 5..7 → LOAD.
- Channel offsets, latched in LOAD:
  - seg = (lim_r+1)>>log2(NCH);
  - off_k = k*seg for k in 0..NCH-1.
  - Channel k pre flag is set in the cen cycle where cnt==(off_k==0 ? lim_r : off_k-1).
  - Channel k preb flag is set where cnt equals (off_k + (lim_r>>1)) mod (lim_r+1).
  - With NCH=1 this reproduces the original timing exactly.
- Outputs:
  - Flags are registered on cen cycles and cleared on every other cen cycle.
  - cen_lo[k] = pre_k & cen and cenb_lo[k] = preb_k & cen. The strobe therefore appears on the cen pulse after the matching count: one cen latency.
  - Strobes never appear on cycles with cen=0.
- Period 2 (sel 3) with NCH>1:
  - seg=1 for NCH=2;
  - NCH=4 forces seg=0, so all channel offsets are 0 (channels coincide). This is legal and documented.
- Mode change while cen is low: ignored until the next cen cycle.
- Reset asserted mid-period: immediate return to the reset values above. After deassertion the first cen cycle is LOAD.
- Simultaneous wrap and resync: resync wins; cnt←0, pre for channel 0 is still set, and the FSM goes to LOAD if a mode change is pending.

Optional Feature:
- Macro: JT5205_TIMING_RESYNC_EN.
- Defined: on a cen cycle in RUN with resync=1:
  - cnt←0 and all pending flags are cleared;
  - a pending mode change is taken (→ LOAD);
  - otherwise the period restarts with no strobe emitted;
  - first cen_lo[0] after lim_r+1 further cen cycles.
- Undefined: resync is ignored; no logic is generated for it.

Test Plan:
- sel=0, cen every 4 clk, NCH=1 → cen_lo every 384 clk, cenb_lo 192 clk after each cen_lo, cen_mid period 192 clk, each strobe exactly one clk wide.
- sel=4, lim_cfg=9, cen continuous → cen_lo period 10 clk; lim_cfg=0 → period 2 clk (clamped).
- sel 0→2 switched at cnt=40 → current 96-cycle period completes, then one LOAD cycle, then 48-cycle periods; no short period observed.
- sel=1, NCH=4 → cen_lo[0..3] spaced 16 cen apart, cenb_lo[k] 32 cen after cen_lo[k].
- sel=6 mid-period → period finishes, stopped=1, no strobes for 1000 cen. sel=3 → LOAD, then cen_lo every 2 cen.
- rst pulsed at cnt=30 → outputs 0 within the same cycle, phase=0. With JT5205_TIMING_RESYNC_EN defined, resync at cnt=50 in sel 0 → next cen_lo after 96 more cen.
